// File: rtl/batch_sequencer.sv
// batch_sequencer: buffers up to DEPTH operands, launches one control-block
// calculation per operand and collects each datapath result into a
// result buffer. Reports batch completion (done) and timeout abort (err).
module batch_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     go,
  input  logic                     clear,
  input  logic                     cb_ready,
  input  logic                     cb_valid,
  input  logic [WIDTH-1:0]         s_in,
  output logic                     cb_start,
  output logic [WIDTH-1:0]         x_out,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    idx;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] op_mem  [DEPTH];
  logic [WIDTH-1:0] res_mem [DEPTH];

  logic             op_we;
  logic             res_we;
  logic             go_ok;
  logic             last_op;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] first_op;

  // Buffer write enables, batch-start qualification and operand forwarding
  always_comb begin
    op_we      = (state == IDLE) && load_en && !clear && !full;
    count_next = count + {{AW{1'b0}}, op_we};
    go_ok      = (state == IDLE) && go && !clear && (count_next != '0);
    // A word loaded in the same cycle as go into an empty buffer is not yet
    // in op_mem, so forward it straight to x_out.
    first_op   = (op_we && (count == '0)) ? load_data : op_mem[0];
    res_we     = (state == WAIT) && cb_valid;
    last_op    = ({1'b0, idx} == (count - (AW+1)'(1)));
  end

  assign full     = (count == (AW+1)'(DEPTH));
  assign busy     = (state == ISSUE) || (state == WAIT);
  // The pulse must coincide with cb_ready inside ISSUE, so it is decoded
  // from the state register rather than registered a cycle late.
  assign cb_start = (state == ISSUE) && cb_ready;

  // Batch control FSM: loading, issue/wait per operand, completion flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      idx   <= '0;
      timer <= '0;
      x_out <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            count <= '0;
          end else begin
            count <= count_next;
            if (go_ok) begin
              idx   <= '0;
              x_out <= first_op;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (cb_ready) begin
            timer <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (cb_valid) begin
            if (last_op) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + AW'(1);
              x_out <= op_mem[idx + AW'(1)];
              state <= ISSUE;
            end
          end else if (timer == TW'(TIMEOUT - 2)) begin
            // timer reads 0 in the first WAIT cycle, so this fires in the
            // cycle TIMEOUT-1 after the pulse and done/err rise TIMEOUT
            // cycles after it.
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (clear) begin
            count <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            state <= IDLE;
          end else if (go) begin
            idx   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            x_out <= op_mem[0];
            state <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand and result buffers, written without reset so they map to RAM
  always_ff @(posedge clock) begin
    if (op_we) begin
      op_mem[count[AW-1:0]] <= load_data;
    end
    if (res_we) begin
      res_mem[idx] <= s_in;
    end
  end

  // Registered result read port, one cycle of latency in every state
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= res_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_batch_sequencer.sv
// tb_batch_sequencer: randomized and directed batches against a queue-based
// model of the buffer plus a cycle model of the 10-state control block.
module tb_batch_sequencer;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int AW      = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             go;
  logic             clear;
  logic             cb_ready;
  logic             cb_valid;
  logic [WIDTH-1:0] s_in;
  logic             cb_start;
  logic [WIDTH-1:0] x_out;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      count;
  logic             full;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clock = ~clock;

  batch_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_data(load_data),
    .go(go), .clear(clear), .cb_ready(cb_ready), .cb_valid(cb_valid),
    .s_in(s_in), .cb_start(cb_start), .x_out(x_out), .rd_addr(rd_addr),
    .rd_data(rd_data), .count(count), .full(full), .busy(busy),
    .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // reference model: buffered operands and expected result buffer
  logic [WIDTH-1:0] mops[$];
  logic [WIDTH-1:0] exp_res [DEPTH];
  int               mul = 2;
  int               add = 0;

  // control-block model and pulse log
  int               cb_cnt  = -1;
  bit               cb_mute = 1'b0;
  bit               cb_hold = 1'b0;
  logic [WIDTH-1:0] cb_x    = '0;
  int               pulses  = 0;
  logic [WIDTH-1:0] pulse_x[$];
  int               cyc     = 0;
  int               last_pulse_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic logic [WIDTH-1:0] calc(input logic [WIDTH-1:0] x);
    return WIDTH'(int'(x) * mul + add);
  endfunction

  // one clock: sample the start pulse mid-cycle, then advance the CB model
  task automatic cycle();
    @(negedge clock);
    if (cb_start === 1'b1) begin
      pulses++;
      pulse_x.push_back(x_out);
      last_pulse_cyc = cyc;
      cb_cnt = 0;
      cb_x   = x_out;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (cb_cnt >= 0) cb_cnt++;
    if (cb_cnt > 10) cb_cnt = -1;
    cb_ready = !cb_hold && (cb_cnt < 0 || cb_cnt >= 10);
    cb_valid = !cb_mute && (cb_cnt == 8);
    s_in     = cb_valid ? calc(cb_x) : WIDTH'($urandom);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    mops.delete();
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    load_en   = 1'b1;
    load_data = v;
    cycle();
    load_en   = 1'b0;
    if (mops.size() < DEPTH) mops.push_back(v);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      cycle();
      n++;
    end
    check({tag, "_done"}, 32'(done), 1);
  endtask

  // launch the buffered batch (optionally loading v in the go cycle) and
  // check pulses, flags and every result against the model
  task automatic run_batch(input string tag, input bit with_load, input logic [WIDTH-1:0] v);
    pulses = 0;
    pulse_x.delete();
    go = 1'b1;
    if (with_load) begin
      load_en   = 1'b1;
      load_data = v;
      if (mops.size() < DEPTH) mops.push_back(v);
    end
    cycle();
    go      = 1'b0;
    load_en = 1'b0;
    wait_done(tag);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_pulses"}, pulses, mops.size());
    check({tag, "_count"}, 32'(count), mops.size());
    for (int i = 0; i < mops.size(); i++) begin
      exp_res[i] = calc(mops[i]);
      if (i < pulse_x.size()) check({tag, "_x"}, 32'(pulse_x[i]), 32'(mops[i]));
    end
    for (int i = 0; i < mops.size(); i++) begin
      rd_addr = AW'(i);
      cycle();
      check({tag, "_rd"}, 32'(rd_data), 32'(exp_res[i]));
    end
    $display("batch %s ops=%0d pulses=%0d done=%0d err=%0d", tag, mops.size(), pulses, done, err);
  endtask

  initial begin
    int n;
    int nops;
    reset = 1'b1; load_en = 1'b0; load_data = '0; go = 1'b0; clear = 1'b0;
    cb_ready = 1'b1; cb_valid = 1'b0; s_in = '0; rd_addr = '0;
    cycle();
    cycle();
    reset = 1'b0;

    // reset state
    check("rst_count", 32'(count), 0);
    check("rst_full", 32'(full), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_start", 32'(cb_start), 0);
    check("rst_x", 32'(x_out), 0);
    check("rst_rd", 32'(rd_data), 0);

    // directed batch 3, 7, 12 with s_in = 2*x
    mul = 2; add = 0;
    load(8'd3); load(8'd7); load(8'd12);
    run_batch("basic", 1'b0, '0);

    // overfill: fifth word discarded, four operands processed
    do_clear();
    for (int i = 0; i < 5; i++) load(WIDTH'($urandom));
    check("fill_count", 32'(count), DEPTH);
    check("fill_full", 32'(full), 1);
    run_batch("full", 1'b0, '0);

    // randomized batches
    for (int b = 0; b < 4; b++) begin
      do_clear();
      mul  = int'($urandom_range(1, 255));
      add  = int'($urandom_range(0, 255));
      nops = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < nops; i++) load(WIDTH'($urandom));
      run_batch("rand", 1'b0, '0);
    end

    // cb_ready withheld for 20 cycles after go
    do_clear();
    load(WIDTH'($urandom));
    cb_hold = 1'b1; cb_ready = 1'b0;
    pulses = 0; pulse_x.delete();
    go = 1'b1; cycle(); go = 1'b0;
    repeat (20) cycle();
    check("hold_pulses", pulses, 0);
    check("hold_err", 32'(err), 0);
    check("hold_busy", 32'(busy), 1);
    cb_hold = 1'b0; cb_ready = 1'b1;
    cycle();
    check("hold_release", pulses, 1);
    wait_done("hold");
    check("hold_err2", 32'(err), 0);
    exp_res[0] = calc(mops[0]);
    rd_addr = '0; cycle();
    check("hold_rd", 32'(rd_data), 32'(exp_res[0]));
    $display("batch hold ops=1 pulses=%0d done=%0d err=%0d", pulses, done, err);

    // timeout: control block never answers
    do_clear();
    load(WIDTH'($urandom)); load(WIDTH'($urandom));
    cb_mute = 1'b1;
    pulses = 0; pulse_x.delete();
    go = 1'b1; cycle(); go = 1'b0;
    wait_done("tmo");
    check("tmo_err", 32'(err), 1);
    check("tmo_latency", cyc - last_pulse_cyc, TIMEOUT);
    check("tmo_pulses", pulses, 1);
    cb_mute = 1'b0;
    rd_addr = '0; cycle();
    check("tmo_nowrite", 32'(rd_data), 32'(exp_res[0]));
    $display("batch tmo ops=2 pulses=%0d done=%0d err=%0d", pulses, done, err);

    // load and go in the same cycle with one word already buffered
    do_clear();
    check("clr_err", 32'(err), 0);
    load(WIDTH'($urandom));
    run_batch("loadgo", 1'b1, WIDTH'($urandom));

    // go with an empty buffer is ignored
    do_clear();
    pulses = 0;
    go = 1'b1; cycle(); go = 1'b0;
    check("empty_busy", 32'(busy), 0);
    repeat (3) cycle();
    check("empty_pulses", pulses, 0);

    // reset while waiting on operand 2
    load(8'd21); load(8'd22); load(8'd23);
    pulses = 0; pulse_x.delete();
    go = 1'b1; cycle(); go = 1'b0;
    n = 0;
    while (pulses < 2 && n < 100) begin cycle(); n++; end
    check("mid_pulse2", pulses, 2);
    repeat (3) cycle();
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1; cycle(); reset = 1'b0;
    mops.delete();
    check("mid_busy0", 32'(busy), 0);
    check("mid_count0", 32'(count), 0);
    check("mid_done0", 32'(done), 0);
    check("mid_err0", 32'(err), 0);
    check("mid_x0", 32'(x_out), 0);
    check("mid_rd0", 32'(rd_data), 0);
    check("mid_start0", 32'(cb_start), 0);
    repeat (30) cycle();
    check("mid_nopulse", pulses, 2);

    // clear and go together in DONE: clear wins
    load(WIDTH'($urandom));
    run_batch("cg", 1'b0, '0);
    clear = 1'b1; go = 1'b1; cycle(); clear = 1'b0; go = 1'b0;
    mops.delete();
    check("cg_count", 32'(count), 0);
    check("cg_done", 32'(done), 0);
    check("cg_busy", 32'(busy), 0);
    repeat (5) cycle();
    check("cg_pulses", pulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/batch_sequencer.md
Name: batch_sequencer

Overview:
- Upstream feeder for the iterative-calculation control block and its datapath.
- Buffers a batch of up to DEPTH operands and launches one calculation per operand: drives the operand onto the datapath X input and pulses start into the control block.
- Captures each datapath result on the control block's valid, stores it in a result buffer, and flags batch completion or timeout.

Parameters:
WIDTH, 8, operand/result width in bits
DEPTH, 4, operand/result buffer entries (power of two, >=2)
TIMEOUT, 15, max cycles waited for cb_valid after a start pulse

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
load_en  in  1  write load_data into next free operand slot
load_data  in  WIDTH  operand to buffer
go  in  1  start processing the buffered batch
clear  in  1  empty buffer, drop done/err (honoured in IDLE/DONE only)
cb_ready  in  1  control block idle (its state 0)
cb_valid  in  1  control block result valid
s_in  in  WIDTH  datapath result (Reg_S)
cb_start  out  1  one-cycle start pulse to control block
x_out  out  WIDTH  operand driven to datapath X register input
rd_addr  in  log2(DEPTH)  result buffer read address
rd_data  out  WIDTH  registered read of result[rd_addr]
count  out  log2(DEPTH)+1  number of buffered operands
full  out  1  count == DEPTH
busy  out  1  state is ISSUE or WAIT
done  out  1  batch finished (level, held in DONE)
err  out  1  batch aborted by timeout (level, held in DONE)

Behaviour:
- Reset: state IDLE. count, idx and timer = 0. cb_start, x_out, rd_data, busy, done, err = 0. Buffer contents are don't-care.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - load_en && !full: op[count] <= load_data, count++.
  - load_en when full: ignored, count unchanged.
  - go && count_next > 0: idx <= 0, go to ISSUE.
  - load_en and go in the same cycle: the write is accepted and is part of the batch.
  - go with count 0: ignored.
- ISSUE:
  - x_out = op[idx], held stable from ISSUE entry until leaving WAIT.
  - When cb_ready = 1: cb_start = 1 for exactly that cycle, timer <= 0, go to WAIT.
  - When cb_ready = 0: stay; no pulse; no timeout in ISSUE.
- WAIT:
  - timer increments each cycle.
  - On cb_valid: res[idx] <= s_in (value sampled that same cycle).
    - idx == count-1: go to DONE.
    - Otherwise idx++, go to ISSUE. The next start waits for cb_ready, which returns after the control block wraps 9->0.
  - timer reaches TIMEOUT without cb_valid: err <= 1, go to DONE, no result write.
  - cb_valid on the same cycle timer hits TIMEOUT: the valid wins; no error.
- DONE: done = 1; err held.
  - clear: count, done and err <= 0, go to IDLE.
  - go: rerun the same buffered batch (idx <= 0, done/err <= 0, ISSUE).
  - clear and go together: clear wins.
- load_en, go and clear are ignored in ISSUE/WAIT.
- cb_start is never asserted outside ISSUE. At most one pulse per operand.
- rd_data <= res[rd_addr] every cycle (1-cycle latency), in any state.
- busy = (state == ISSUE || state == WAIT).
- Reset mid-batch returns to IDLE with all counters at 0. No further cb_start is issued.
- Nominal per-operand latency with the 10-state control block: start at T, cb_valid at T+8, next cb_ready at T+10.

Test Plan:
- Load 3, 7, 12, then go; model the control block (valid 8 cycles after start, ready 2 cycles after that) with s_in = 2*x → res = 6, 14, 24; exactly 3 cb_start pulses; done = 1, err = 0; rd_addr 0..2 returns 6, 14, 24 one cycle later.
- Load 5 words into DEPTH = 4 → count = 4, full = 1, 5th word discarded; go processes exactly 4 operands.
- cb_ready held 0 for 20 cycles after go → no cb_start, no err; release cb_ready → single pulse on the next cycle.
- cb_valid never asserted after start → err = 1 and done = 1 exactly TIMEOUT = 15 cycles after the pulse; no result written.
- load_en and go in the same IDLE cycle with count = 1 → batch of 2 processed; go with count = 0 → stays IDLE.
- Assert reset during WAIT of operand 2 → all outputs 0 next cycle; no cb_start afterwards; clear/go in DONE with both high → IDLE, count = 0.
